// File: rtl/liang_pkg.sv
// Shared core types: uop bundle and ALU issue-queue entry layout.
package liang_pkg;

    localparam int XLEN     = 32;
    localparam int IQ_DEPTH = 4;
    localparam int TAG_W    = 4;

    typedef enum logic [2:0] {
        FU_ALU,
        FU_BR,
        FU_MUL,
        FU_DIV,
        FU_LSU,
        FU_CSR
    } fu_op_t;

    typedef struct packed {
        fu_op_t            fu_op;
        logic [3:0]        fu_func;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   imm;
    } uop_info_t;

    typedef struct packed {
        logic [XLEN-1:0]   val;
        logic              rdy;
        logic [TAG_W-1:0]  tag;
    } iq_operand_t;

    typedef struct packed {
        logic              valid;
        uop_info_t         uop;
        iq_operand_t       src1;
        iq_operand_t       src2;
    } iq_entry_t;

    function automatic logic tag_hit(
        input logic             live,
        input iq_operand_t      op,
        input logic             wb_valid,
        input logic [TAG_W-1:0] wb_tag
    );
        return live && wb_valid && !op.rdy && (op.tag == wb_tag);
    endfunction

endpackage

// File: rtl/alu_iq_operand.sv
// Operand wakeup: captures the broadcast result when the pending tag matches.
module alu_iq_operand
    import liang_pkg::*;
(
    input  logic              live_i,
    input  iq_operand_t       op_i,
    input  logic              wb_valid_i,
    input  logic [TAG_W-1:0]  wb_tag_i,
    input  logic [XLEN-1:0]   wb_data_i,
    output iq_operand_t       op_o
);

    always_comb begin
        op_o = op_i;
        if (tag_hit(live_i, op_i, wb_valid_i, wb_tag_i)) begin
            op_o.val = wb_data_i;
            op_o.rdy = 1'b1;
        end
    end

endmodule

// File: rtl/alu_issue_queue.sv
// Collapsing age-ordered ALU issue queue with writeback wakeup.
// Define ALU_IQ_WAKEUP_BYPASS_EN to let a broadcast wake and issue in one cycle.
module alu_issue_queue
    import liang_pkg::*;
#(
    parameter int DEPTH = IQ_DEPTH,
    parameter int TAG_W = liang_pkg::TAG_W
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       enq_valid_i,
    output logic                       enq_ready_o,
    input  uop_info_t                  enq_uop_i,
    input  logic [XLEN-1:0]            enq_rs1_val_i,
    input  logic [XLEN-1:0]            enq_rs2_val_i,
    input  logic                       enq_rs1_rdy_i,
    input  logic                       enq_rs2_rdy_i,
    input  logic [TAG_W-1:0]           enq_rs1_tag_i,
    input  logic [TAG_W-1:0]           enq_rs2_tag_i,
    input  logic                       wb_valid_i,
    input  logic [TAG_W-1:0]           wb_tag_i,
    input  logic [XLEN-1:0]            wb_data_i,
    output logic                       iss_valid_o,
    input  logic                       iss_ready_i,
    output uop_info_t                  iss_uop_o,
    output logic [XLEN-1:0]            iss_rs1_o,
    output logic [XLEN-1:0]            iss_rs2_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int CW = $clog2(DEPTH+1);

    iq_entry_t   ent_q [DEPTH];
    iq_entry_t   ent_w [DEPTH];
    iq_entry_t   ent_d [DEPTH];
    iq_entry_t   cand  [DEPTH];
    iq_operand_t s1_w  [DEPTH];
    iq_operand_t s2_w  [DEPTH];
    iq_operand_t enq_s1, enq_s2;
    iq_operand_t enq_s1_w, enq_s2_w;
    iq_entry_t   enq_e;
    iq_entry_t   sel_ent;
    logic [CW-1:0] count_q, sel, enq_idx;
    logic        found, iss_fire, enq_fire;

    for (genvar g = 0; g < DEPTH; g++) begin : g_ent
        alu_iq_operand u_src1 (
            .live_i     (ent_q[g].valid),
            .op_i       (ent_q[g].src1),
            .wb_valid_i (wb_valid_i),
            .wb_tag_i   (wb_tag_i),
            .wb_data_i  (wb_data_i),
            .op_o       (s1_w[g])
        );
        alu_iq_operand u_src2 (
            .live_i     (ent_q[g].valid),
            .op_i       (ent_q[g].src2),
            .wb_valid_i (wb_valid_i),
            .wb_tag_i   (wb_tag_i),
            .wb_data_i  (wb_data_i),
            .op_o       (s2_w[g])
        );
        always_comb begin
            ent_w[g]       = ent_q[g];
            ent_w[g].src1  = s1_w[g];
            ent_w[g].src2  = s2_w[g];
        end
    end

    assign enq_s1 = '{val: enq_rs1_val_i, rdy: enq_rs1_rdy_i, tag: enq_rs1_tag_i};
    assign enq_s2 = '{val: enq_rs2_val_i, rdy: enq_rs2_rdy_i, tag: enq_rs2_tag_i};

    // Incoming operands see the same broadcast so no wakeup is lost at enqueue.
    alu_iq_operand u_enq_src1 (
        .live_i     (1'b1),
        .op_i       (enq_s1),
        .wb_valid_i (wb_valid_i),
        .wb_tag_i   (wb_tag_i),
        .wb_data_i  (wb_data_i),
        .op_o       (enq_s1_w)
    );
    alu_iq_operand u_enq_src2 (
        .live_i     (1'b1),
        .op_i       (enq_s2),
        .wb_valid_i (wb_valid_i),
        .wb_tag_i   (wb_tag_i),
        .wb_data_i  (wb_data_i),
        .op_o       (enq_s2_w)
    );

    assign enq_e = '{valid: 1'b1, uop: enq_uop_i, src1: enq_s1_w, src2: enq_s2_w};

`ifdef ALU_IQ_WAKEUP_BYPASS_EN
    assign cand = ent_w;
`else
    assign cand = ent_q;
`endif

    always_comb begin
        found   = 1'b0;
        sel     = '0;
        sel_ent = '0;
        for (int i = DEPTH-1; i >= 0; i--) begin
            if (cand[i].valid && cand[i].src1.rdy && cand[i].src2.rdy) begin
                found   = 1'b1;
                sel     = CW'(i);
                sel_ent = cand[i];
            end
        end
    end

    assign enq_ready_o = (count_q < CW'(DEPTH));
    assign iss_valid_o = !flush_i && found;
    assign iss_uop_o   = iss_valid_o ? sel_ent.uop      : '0;
    assign iss_rs1_o   = iss_valid_o ? sel_ent.src1.val : '0;
    assign iss_rs2_o   = iss_valid_o ? sel_ent.src2.val : '0;
    assign count_o     = count_q;

    assign iss_fire = iss_valid_o && iss_ready_i;
    assign enq_fire = enq_valid_i && enq_ready_o && !flush_i;
    assign enq_idx  = count_q - CW'(iss_fire);

    always_comb begin
        for (int i = 0; i < DEPTH; i++) ent_d[i] = ent_w[i];
        // Younger entries collapse over the issued slot.
        if (iss_fire) begin
            for (int i = 0; i < DEPTH-1; i++) begin
                if (CW'(i) >= sel) ent_d[i] = ent_w[i+1];
            end
            ent_d[DEPTH-1] = '0;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (enq_fire && CW'(i) == enq_idx) ent_d[i] = enq_e;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
        end else if (flush_i) begin
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
        end else begin
            count_q <= count_q + CW'(enq_fire) - CW'(iss_fire);
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
        end
    end

endmodule
